// File: rtl/tx_eq_pkg.sv
// Shared types, preset tap tables and legality constants for the TX equaliser
// coefficient path.
package tx_eq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2,
        RESP  = 2'd3
    } eq_state_e;

    localparam logic [5:0] FS_MIN      = 6'd24;
    localparam logic [3:0] NUM_PRESETS = 4'd11;

    // Numerators in 1/32 of FS for each preset.
    localparam logic [3:0] PRE_NUM  [0:10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3,
                                               4'd4, 4'd3, 4'd4, 4'd5, 4'd0};
    localparam logic [3:0] POST_NUM [0:10] = '{4'd8, 4'd5, 4'd6, 4'd4, 4'd0, 4'd0,
                                               4'd0, 4'd7, 4'd5, 4'd0, 4'd10};

    function automatic logic [3:0] pre_num(input logic [3:0] p);
        if (p < NUM_PRESETS) return PRE_NUM[p];
        return 4'd0;
    endfunction

    function automatic logic [3:0] post_num(input logic [3:0] p);
        if (p < NUM_PRESETS) return POST_NUM[p];
        return 4'd0;
    endfunction

endpackage

// File: rtl/tx_eq_rule_check.sv
// Combinational FS/LF legality rules for a (C-1, C+1) pair; also resolves C0.
module tx_eq_rule_check
    import tx_eq_pkg::*;
(
    input  logic [5:0] fs,
    input  logic [5:0] lf,
    input  logic [5:0] cm,
    input  logic [5:0] cp,
    output logic [5:0] c0,
    output logic       legal
);

    logic signed [7:0] c0_s;
    logic signed [9:0] margin;

    always_comb begin
        c0_s   = $signed({2'b00, fs}) - $signed({2'b00, cm}) - $signed({2'b00, cp});
        // Eye margin: main cursor minus both taps must stay above LF.
        margin = 10'(c0_s) - $signed({4'b0000, cm}) - $signed({4'b0000, cp});
        c0     = c0_s[5:0];
        legal  = (fs >= FS_MIN)
              && (lf <= fs)
              && !c0_s[7]
              && (cm <= {2'b00, fs[5:2]})
              && (margin >= $signed({4'b0000, lf}));
    end

endmodule

// File: rtl/tx_eq_coeff_ctrl.sv
// TX equalisation coefficient controller: resolves preset/explicit requests,
// checks legality and applies legal sets to the driver after a hold-off.
module tx_eq_coeff_ctrl
    import tx_eq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int RESET_C0    = 63
) (
    input  logic       bit_clk,
    input  logic       reset,
    input  logic [5:0] FS,
    input  logic [5:0] LF,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_preset,
    input  logic [3:0] req_preset,
    input  logic [5:0] req_c1_minus,
    input  logic [5:0] req_c1_plus,
    output logic       rsp_valid,
    output logic       rsp_reject,
    output logic [5:0] C0,
    output logic [5:0] C1_minus,
    output logic [5:0] C1_plus,
    output logic       coeff_update,
    output eq_state_e  fsm_state
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Handshake: a request transfers on a rising bit_clk edge where
    // req_valid & req_ready are both high; req_ready is high only in IDLE.

    eq_state_e   state, state_next;
    logic [CW-1:0] cnt;

    logic       is_preset_q;
    logic [3:0] preset_q;
    logic [5:0] xm_q, xp_q;

    logic [5:0] cand_c0, cand_cm, cand_cp;
    logic       reject_q;

    logic [9:0] pre_prod, post_prod;
    logic [5:0] res_cm, res_cp, res_c0;
    logic       rule_legal, legal;

    always_comb begin
        pre_prod  = {4'b0000, FS} * {6'b000000, pre_num(preset_q)};
        post_prod = {4'b0000, FS} * {6'b000000, post_num(preset_q)};
        res_cm    = is_preset_q ? {1'b0, pre_prod[9:5]}  : xm_q;
        res_cp    = is_preset_q ? {1'b0, post_prod[9:5]} : xp_q;
    end

    tx_eq_rule_check u_rule_check (
        .fs    (FS),
        .lf    (LF),
        .cm    (res_cm),
        .cp    (res_cp),
        .c0    (res_c0),
        .legal (rule_legal)
    );

    assign legal = rule_legal && (!is_preset_q || (preset_q < NUM_PRESETS));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (req_valid)     state_next = CHECK;
            CHECK: state_next = legal ? HOLD : RESP;
            HOLD:  if (cnt == '0)     state_next = RESP;
            // On the accept path RESP first waits out the coeff_update cycle.
            RESP:  if (!coeff_update) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge bit_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_preset_q  <= 1'b0;
            preset_q     <= 4'd0;
            xm_q         <= 6'd0;
            xp_q         <= 6'd0;
            cand_c0      <= 6'd0;
            cand_cm      <= 6'd0;
            cand_cp      <= 6'd0;
            reject_q     <= 1'b0;
            C0           <= 6'(RESET_C0);
            C1_minus     <= 6'd0;
            C1_plus      <= 6'd0;
            coeff_update <= 1'b0;
        end else begin
            state        <= state_next;
            coeff_update <= 1'b0;
            if (state == IDLE && req_valid) begin
                is_preset_q <= req_is_preset;
                preset_q    <= req_preset;
                xm_q        <= req_c1_minus;
                xp_q        <= req_c1_plus;
            end
            if (state == CHECK) begin
                cand_c0  <= res_c0;
                cand_cm  <= res_cm;
                cand_cp  <= res_cp;
                reject_q <= !legal;
                cnt      <= CW'(HOLD_CYCLES - 1);
            end
            if (state == HOLD) begin
                if (cnt == '0) begin
                    C0           <= cand_c0;
                    C1_minus     <= cand_cm;
                    C1_plus      <= cand_cp;
                    coeff_update <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP) && !coeff_update;
    assign rsp_reject = rsp_valid && reject_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_tx_eq_coeff_ctrl.sv
// Bench for tx_eq_coeff_ctrl: event-timed behavioural model checked every cycle,
// directed scenarios plus randomized requests with FS/LF jitter and resets.
module tb_tx_eq_coeff_ctrl;
    import tx_eq_pkg::*;

    localparam int HOLD = 16;

    logic       bit_clk = 1'b0;
    logic       reset;
    logic [5:0] FS, LF;
    logic       req_valid, req_ready, req_is_preset;
    logic [3:0] req_preset;
    logic [5:0] req_c1_minus, req_c1_plus;
    logic       rsp_valid, rsp_reject, coeff_update;
    logic [5:0] C0, C1_minus, C1_plus;
    eq_state_e  fsm_state;

    tx_eq_coeff_ctrl #(.HOLD_CYCLES(HOLD), .RESET_C0(63)) dut (
        .bit_clk       (bit_clk),
        .reset         (reset),
        .FS            (FS),
        .LF            (LF),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_preset (req_is_preset),
        .req_preset    (req_preset),
        .req_c1_minus  (req_c1_minus),
        .req_c1_plus   (req_c1_plus),
        .rsp_valid     (rsp_valid),
        .rsp_reject    (rsp_reject),
        .C0            (C0),
        .C1_minus      (C1_minus),
        .C1_plus       (C1_plus),
        .coeff_update  (coeff_update),
        .fsm_state     (fsm_state)
    );

    always #5 bit_clk = ~bit_clk;

    int cyc = 0;
    always @(posedge bit_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int pre_tab  [11] = '{0, 0, 0, 0, 0, 3, 4, 3, 4, 5, 0};
    int post_tab [11] = '{8, 5, 6, 4, 0, 0, 0, 7, 5, 0, 10};

    function automatic void eval_req(input int fs, input int lf, input int is_p, input int p,
                                     input int xm, input int xp,
                                     output int legal, output int c0, output int cm, output int cp);
        if (is_p != 0) begin
            if (p > 10) begin
                legal = 0; cm = 0; cp = 0; c0 = fs;
                return;
            end
            cm = (fs * pre_tab[p]) / 32;
            cp = (fs * post_tab[p]) / 32;
        end else begin
            cm = xm;
            cp = xp;
        end
        c0 = fs - cm - cp;
        legal = (fs >= 24 && lf <= fs && c0 >= 0 && cm <= fs / 4 && (c0 - cm - cp) >= lf) ? 1 : 0;
    endfunction

    bit m_busy = 0;
    int m_chk = -1, m_upd = -1, m_rsp = -1;
    int m_legal = 0, m_c0 = 0, m_cm = 0, m_cp = 0;
    int q_is_p, q_p, q_xm, q_xp;
    int app_c0 = 63, app_cm = 0, app_cp = 0;
    int last_rej = -1;
    int rsp_cnt = 0;

    always @(negedge bit_clk) begin
        bit exp_rsp, exp_upd, was_busy;
        if (reset) begin
            m_busy = 0;
            app_c0 = 63; app_cm = 0; app_cp = 0;
        end else if (m_busy && cyc == m_chk) begin
            eval_req(int'(FS), int'(LF), q_is_p, q_p, q_xm, q_xp, m_legal, m_c0, m_cm, m_cp);
            m_upd = m_chk + 1 + HOLD;
            m_rsp = (m_legal != 0) ? m_chk + 2 + HOLD : m_chk + 1;
        end
        exp_upd = m_busy && (m_legal != 0) && (cyc == m_upd);
        exp_rsp = m_busy && (cyc == m_rsp);
        if (exp_upd) begin
            app_c0 = m_c0; app_cm = m_cm; app_cp = m_cp;
        end
        check("req_ready", int'(req_ready), int'(!m_busy));
        check("rsp_valid", int'(rsp_valid), int'(exp_rsp));
        check("coeff_update", int'(coeff_update), int'(exp_upd));
        check("C0", int'(C0), app_c0);
        check("C1_minus", int'(C1_minus), app_cm);
        check("C1_plus", int'(C1_plus), app_cp);
        if (exp_rsp) check("rsp_reject", int'(rsp_reject), int'(m_legal == 0));
        if (rsp_valid) begin
            last_rej = int'(rsp_reject);
            rsp_cnt++;
        end
        was_busy = m_busy;
        if (m_busy && cyc == m_rsp) m_busy = 0;
        if (!reset && !was_busy && req_valid) begin
            m_busy = 1;
            m_chk  = cyc + 1;
            m_upd  = -1;
            m_rsp  = -1;
            q_is_p = int'(req_is_preset);
            q_p    = int'(req_preset);
            q_xm   = int'(req_c1_minus);
            q_xp   = int'(req_c1_plus);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge bit_clk); #2;
            n++;
        end
        check("ready_timeout", int'(req_ready), 1);
    endtask

    task automatic send(input int is_p, input int p, input int xm, input int xp);
        @(posedge bit_clk); #2;
        wait_ready();
        req_valid     = 1'b1;
        req_is_preset = 1'(is_p);
        req_preset    = 4'(p);
        req_c1_minus  = 6'(xm);
        req_c1_plus   = 6'(xp);
        @(posedge bit_clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic finish_req();
        @(posedge bit_clk); #2;
        wait_ready();
    endtask

    task automatic expect_coeffs(input string name, input int c0, input int cm, input int cp);
        check({name, "_C0"}, int'(C0), c0);
        check({name, "_C1_minus"}, int'(C1_minus), cm);
        check({name, "_C1_plus"}, int'(C1_plus), cp);
    endtask

    initial begin
        int lg, c0, cm, cp, n, rc;
        bit in_rst;
        reset = 1'b1; FS = 6'd63; LF = 6'd20; req_valid = 1'b0;
        req_is_preset = 1'b0; req_preset = 4'd0; req_c1_minus = 6'd0; req_c1_plus = 6'd0;

        // Pin the model with hand-derived values.
        eval_req(63, 20, 1, 0, 0, 0, lg, c0, cm, cp);
        check("model_p0_legal", lg, 1); check("model_p0_c0", c0, 48); check("model_p0_cp", cp, 15);
        eval_req(63, 20, 0, 0, 16, 0, lg, c0, cm, cp);
        check("model_cm16_legal", lg, 0);
        eval_req(63, 40, 0, 0, 5, 10, lg, c0, cm, cp);
        check("model_lf40_legal", lg, 0); check("model_lf40_c0", c0, 48);
        eval_req(63, 20, 1, 7, 0, 0, lg, c0, cm, cp);
        check("model_p7_c0", c0, 45); check("model_p7_cm", cm, 5); check("model_p7_cp", cp, 13);
        eval_req(20, 0, 1, 4, 0, 0, lg, c0, cm, cp);
        check("model_fs20_legal", lg, 0);

        repeat (3) @(posedge bit_clk);
        #2 reset = 1'b0;
        @(posedge bit_clk); #2;
        expect_coeffs("reset", 63, 0, 0);
        check("reset_ready", int'(req_ready), 1);
        check("reset_state", int'(fsm_state), int'(IDLE));
        check("reset_update", int'(coeff_update), 0);

        send(1, 0, 0, 0); finish_req();
        expect_coeffs("p0", 48, 0, 15);
        check("p0_reject", last_rej, 0);

        send(0, 0, 16, 0); finish_req();
        check("cm16_reject", last_rej, 1);
        expect_coeffs("cm16", 48, 0, 15);

        LF = 6'd40;
        send(0, 0, 5, 10); finish_req();
        check("lf40_reject", last_rej, 1);
        LF = 6'd20;

        send(1, 12, 0, 0); finish_req();
        check("p12_reject", last_rej, 1);
        FS = 6'd20;
        send(1, 4, 0, 0); finish_req();
        check("fs20_reject", last_rej, 1);
        FS = 6'd63;
        expect_coeffs("after_rejects", 48, 0, 15);

        rc = rsp_cnt;
        send(1, 7, 0, 0);
        repeat (5) @(posedge bit_clk);
        #2 reset = 1'b1;
        @(posedge bit_clk); #2 reset = 1'b0;
        expect_coeffs("abort", 63, 0, 0);
        repeat (HOLD + 4) @(posedge bit_clk);
        check("abort_no_rsp", rsp_cnt, rc);
        send(1, 0, 0, 0); finish_req();
        expect_coeffs("post_abort", 48, 0, 15);

        for (int it = 0; it < 250; it++) begin
            @(posedge bit_clk); #2;
            FS = (($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 23)) : 6'($urandom_range(24, 63)));
            LF = 6'($urandom_range(0, 31));
            send(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 12),
                 $urandom_range(0, 16), $urandom_range(0, 24));
            in_rst = 0;
            n = 0;
            while (n < 100) begin
                @(posedge bit_clk); #2;
                n++;
                if (in_rst) begin
                    reset = 1'b0;
                    in_rst = 0;
                end
                if (req_ready) break;
                if ($urandom_range(0, 1) == 0) FS = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 0) LF = 6'($urandom_range(0, 63));
                req_valid     = ($urandom_range(0, 3) == 0);
                req_is_preset = 1'($urandom_range(0, 1));
                req_preset    = 4'($urandom_range(0, 15));
                req_c1_minus  = 6'($urandom_range(0, 20));
                req_c1_plus   = 6'($urandom_range(0, 20));
                if ($urandom_range(0, 60) == 0) begin
                    reset = 1'b1;
                    in_rst = 1;
                end
            end
            reset = 1'b0;
            req_valid = 1'b0;
            check("rand_ready_timeout", int'(req_ready), 1);
        end

        repeat (3) @(posedge bit_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
